// File: rtl/btn_deb_multi.sv
// Multi-channel button debouncer: 2-flop synchronizers, one shared sample tick,
// and per-channel debounce and hold counters with press/release/long-press pulses.
module btn_deb_multi #(
  parameter int N_CH       = 4,
  parameter int TICK_DIV   = 27000,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0]   DEB_MAX   = DW'(DEB_TICKS);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [N_CH-1:0] IDLE_PINS = {N_CH{ACTIVE_LOW}};

  logic [N_CH-1:0] sync1_q, sync2_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [N_CH-1:0] s;

  // Synchronizers idle at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= IDLE_PINS;
      sync2_q    <= IDLE_PINS;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    s          = sync2_q ^ IDLE_PINS;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [DW-1:0] deb_q, deb_d, deb_inc;
      logic [HW-1:0] hold_q, hold_d, hold_inc;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic          long_q, long_d;

      always_comb begin
        deb_d     = deb_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        deb_inc   = deb_q + 1'b1;
        hold_inc  = hold_q + 1'b1;
        if (tick) begin
          if (s[gi] == level_q) begin
            deb_d = '0;
          end else if (deb_inc == DEB_MAX) begin
            deb_d     = '0;
            level_d   = ~level_q;
            press_d   = ~level_q;
            release_d = level_q;
          end else begin
            deb_d = deb_inc;
          end
        end
        // A release on the tick that would complete the hold wins over the long pulse.
        if (!level_q || release_d) begin
          hold_d = '0;
        end else if (tick && (hold_q != HOLD_MAX)) begin
          hold_d = hold_inc;
          long_d = (hold_inc == HOLD_MAX);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          deb_q     <= '0;
          hold_q    <= '0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          long_q    <= 1'b0;
        end else begin
          deb_q     <= deb_d;
          hold_q    <= hold_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
          long_q    <= long_d;
        end
      end

      assign btn_level[gi]   = level_q;
      assign btn_press[gi]   = press_q;
      assign btn_release[gi] = release_q;
      assign btn_long[gi]    = long_q;
    end
  endgenerate

endmodule
